// File: rtl/s382_run_ctrl.sv
// Run controller for an s382 core: steps the core with one gated clock per stored
// stimulus vector and returns each captured output word over a valid/ready channel.
module s382_run_ctrl #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int SETTLE = 2
) (
  input  logic          CK,
  input  logic          RN,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_data,
  input  logic [AW:0]   nvec,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dut_in,
  output logic          dut_ck_en,
  input  logic [5:0]    dut_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [5:0]    res_data,
  output logic [AW-1:0] res_idx
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_APPLY   = 3'd1;
  localparam logic [2:0] S_PRE     = 3'd2;
  localparam logic [2:0] S_STEP    = 3'd3;
  localparam logic [2:0] S_POST    = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [AW:0] DEPTH_V   = (AW+1)'(DEPTH);
  localparam logic [AW:0] IDX_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0] IDX_ONE   = {{AW{1'b0}}, 1'b1};

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   nvec_q, nvec_d;
  logic [2:0]    dut_in_q, dut_in_d;
  logic          res_valid_q, res_valid_d;
  logic [5:0]    res_data_q, res_data_d;
  logic [AW-1:0] res_idx_q, res_idx_d;
  logic [AW:0]   idx_inc_s;
  logic [2:0]    mem_q [DEPTH];

  assign idx_inc_s = idx_q + IDX_ONE;

  // Next-state and datapath update; abort overrides everything outside IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    nvec_d      = nvec_q;
    dut_in_d    = dut_in_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    if (state_q != S_IDLE && abort) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
      cnt_d       = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && nvec != IDX_ZERO) begin
            nvec_d   = (nvec > DEPTH_V) ? DEPTH_V : nvec;
            idx_d    = IDX_ZERO;
            dut_in_d = mem_q[0];
            state_d  = S_APPLY;
          end else if (start) begin
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_APPLY: begin
          cnt_d   = SETTLE_M1;
          state_d = S_PRE;
        end
        S_PRE: begin
          if (cnt_q == 4'd0) begin
            state_d = S_STEP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_STEP: begin
          cnt_d   = SETTLE_M1;
          state_d = S_POST;
        end
        S_POST: begin
          if (cnt_q == 4'd0) begin
            res_data_d  = dut_out;
            res_idx_d   = idx_q[AW-1:0];
            res_valid_d = 1'b1;
            state_d     = S_CAPTURE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_CAPTURE: begin
          if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            idx_d       = idx_inc_s;
            if (idx_inc_s == nvec_q) begin
              state_d = S_DONE;
            end else begin
              dut_in_d = mem_q[idx_inc_s[AW-1:0]];
              state_d  = S_APPLY;
            end
          end else begin
            state_d = S_CAPTURE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and result registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= IDX_ZERO;
      nvec_q      <= IDX_ZERO;
      dut_in_q    <= 3'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 6'd0;
      res_idx_q   <= {AW{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      nvec_q      <= nvec_d;
      dut_in_q    <= dut_in_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
    end
  end

  // Stimulus memory survives reset so a reset run can be replayed.
  always_ff @(posedge CK) begin
    if (wr_en && state_q == S_IDLE) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dut_ck_en = (state_q == S_STEP);
  assign dut_in    = dut_in_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;

endmodule

// File: tb/tb_s382_run_ctrl.sv
// Self-checking bench for s382_run_ctrl: table of run configurations plus hand-written
// abort and mid-run reset sequences, checked against a stand-in core and result model.
module tb_s382_run_ctrl;
  localparam int S   = 2;
  localparam int PER = 2 * S + 3;

  logic       CK, RN, wr_en, start, abort, res_ready;
  logic [3:0] wr_addr, res_idx;
  logic [2:0] wr_data, dut_in;
  logic [4:0] nvec;
  logic       busy, done, dut_ck_en, res_valid;
  logic [5:0] dut_out, res_data;

  s382_run_ctrl #(.DEPTH(16), .AW(4), .SETTLE(S)) dut (
    .CK(CK), .RN(RN), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .nvec(nvec), .start(start), .abort(abort), .busy(busy), .done(done),
    .dut_in(dut_in), .dut_ck_en(dut_ck_en), .dut_out(dut_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // Stand-in core: a 6-bit state stepped only when the controller enables its clock.
  logic [5:0] core_st;
  logic       core_clr;
  always @(posedge CK) begin
    if (core_clr) core_st <= 6'd0;
    else if (dut_ck_en) core_st <= core_st * 6'd5 + {3'b000, dut_in} + 6'd3;
  end
  assign dut_out = core_st ^ {dut_in, 3'b000};

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] mem_m [16];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endfunction

  // Expected result k: core state after stepping vectors 0..k from zero, seen through dut_in=mem[k].
  function automatic logic [5:0] model_res(int k);
    logic [5:0] st;
    st = 6'd0;
    for (int i = 0; i <= k; i++) st = st * 6'd5 + {3'b000, mem_m[i]} + 6'd3;
    return st ^ {mem_m[k], 3'b000};
  endfunction

  // Monitor sampling at the falling edge.
  logic [9:0] res_q[$];
  int         ck_q[$];
  int         busy_cyc, done_cnt;
  bit         mon_en = 1'b0, prev_hold = 1'b0;
  logic [5:0] prev_data;
  logic [3:0] prev_idx;
  always @(negedge CK) begin
    if (mon_en) begin
      if (busy) busy_cyc++;
      if (dut_ck_en) ck_q.push_back(busy_cyc);
      if (done) done_cnt++;
      if (prev_hold) begin
        chk("hold_valid", 32'(res_valid), 32'd1);
        chk("hold_data", 32'(res_data), 32'(prev_data));
        chk("hold_idx", 32'(res_idx), 32'(prev_idx));
      end
      if (res_valid && res_ready && !abort) res_q.push_back({res_idx, res_data});
      prev_hold = res_valid && !res_ready && !abort;
      prev_data = res_data;
      prev_idx  = res_idx;
    end
  end

  task automatic write_mem(input int a, input logic [2:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    @(posedge CK); #1;
    wr_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic begin_run(input int nv);
    core_clr = 1'b1;
    @(posedge CK); #1;
    core_clr = 1'b0;
    res_q.delete(); ck_q.delete();
    busy_cyc = 0; done_cnt = 0; prev_hold = 1'b0; mon_en = 1'b1;
    nvec = 5'(nv); start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
  endtask

  // mode: 0 ready high, 1 random ready, 2 five-cycle stall on result 1
  task automatic run(input int nv, input int mode, input int expn, input bit timing, input bit noise);
    int budget, stall;
    bit stalled;
    int a;
    begin_run(nv);
    budget = 0; stall = 0; stalled = 1'b0;
    while (done_cnt == 0 && budget < 3000) begin
      case (mode)
        1: res_ready = 1'($urandom_range(0, 1));
        2: begin
          if (!stalled && res_valid && res_idx == 4'd1) begin stalled = 1'b1; stall = 5; end
          if (stall > 0) begin res_ready = 1'b0; stall--; end
          else res_ready = 1'b1;
        end
        default: res_ready = 1'b1;
      endcase
      if (noise && budget >= 3 && budget < 20) begin
        a = $urandom_range(0, 15);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = ~mem_m[a]; start = 1'b1; nvec = 5'd2;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(posedge CK); #1;
      budget++;
    end
    wr_en = 1'b0; start = 1'b0; res_ready = 1'b1;
    if (budget >= 3000) begin n_tests++; n_fail++; $display("FAIL run_timeout: got no done, expected done (nvec=%0d)", nv); end
    repeat (3) @(negedge CK);
    mon_en = 1'b0;
    @(posedge CK); #1;
    chk($sformatf("done_once n%0d", nv), 32'(done_cnt), 32'd1);
    chk($sformatf("n_results n%0d", nv), 32'(res_q.size()), 32'(expn));
    chk($sformatf("n_steps n%0d", nv), 32'(ck_q.size()), 32'(expn));
    for (int k = 0; k < expn && k < res_q.size(); k++) begin
      chk($sformatf("res_idx n%0d k%0d", nv, k), 32'(res_q[k][9:6]), 32'(k));
      chk($sformatf("res_data n%0d k%0d", nv, k), 32'(res_q[k][5:0]), 32'(model_res(k)));
    end
    if (timing) begin
      chk($sformatf("busy_cycles n%0d", nv), 32'(busy_cyc), 32'(expn * PER + 1));
      for (int k = 0; k < expn && k < ck_q.size(); k++)
        chk($sformatf("step_time n%0d k%0d", nv, k), 32'(ck_q[k]), 32'(S + 2 + k * PER));
    end
  endtask

  typedef struct { int nv; int mode; int expn; bit timing; bit noise; } run_t;
  run_t tbl[8];

  initial begin
    int b;
    tbl[0] = '{4,  0, 4,  1'b1, 1'b0};
    tbl[1] = '{4,  2, 4,  1'b0, 1'b0};
    tbl[2] = '{0,  0, 0,  1'b1, 1'b0};
    tbl[3] = '{31, 0, 16, 1'b1, 1'b1};
    tbl[4] = '{3,  1, 3,  1'b0, 1'b0};
    tbl[5] = '{16, 1, 16, 1'b0, 1'b0};
    tbl[6] = '{1,  0, 1,  1'b1, 1'b0};
    tbl[7] = '{17, 0, 16, 1'b1, 1'b0};

    RN = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 3'd0; nvec = 5'd0;
    start = 1'b0; abort = 1'b0; res_ready = 1'b1; core_clr = 1'b0;
    #3 RN = 1'b0;
    #1 chk("reset_outs", 32'({busy, done, dut_ck_en, res_valid, dut_in, res_data, res_idx}), 32'd0);
    @(posedge CK); #1;
    chk("reset_held", 32'({busy, done, dut_ck_en, res_valid, dut_in, res_data, res_idx}), 32'd0);
    @(negedge CK); RN = 1'b1;
    @(posedge CK); #1;

    for (int i = 0; i < 16; i++) write_mem(i, 3'($urandom_range(0, 7)));
    write_mem(0, 3'b000); write_mem(1, 3'b001); write_mem(2, 3'b110); write_mem(3, 3'b111);

    for (int t = 0; t < 8; t++) run(tbl[t].nv, tbl[t].mode, tbl[t].expn, tbl[t].timing, tbl[t].noise);

    // Abort during POST of vector 2, then replay from index 0.
    res_ready = 1'b1;
    begin_run(4);
    b = 0;
    while (ck_q.size() < 3 && b < 200) begin @(negedge CK); b++; end
    chk("abort_reach_step2", 32'(ck_q.size()), 32'd3);
    @(posedge CK); #1;
    abort = 1'b1;
    @(posedge CK); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(res_valid), 32'd0);
    repeat (10) @(posedge CK);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_results", 32'(res_q.size()), 32'd2);
    chk("abort_steps", 32'(ck_q.size()), 32'd3);
    mon_en = 1'b0;
    run(4, 0, 4, 1'b1, 1'b0);

    // Asynchronous reset during STEP of vector 3, then replay.
    begin_run(4);
    b = 0;
    while (ck_q.size() < 4 && b < 200) begin @(negedge CK); b++; end
    chk("rst_reach_step3", 32'(ck_q.size()), 32'd4);
    mon_en = 1'b0;
    #1 RN = 1'b0;
    #1 chk("rst_mid_outs", 32'({busy, done, dut_ck_en, res_valid, dut_in, res_data, res_idx}), 32'd0);
    @(negedge CK); RN = 1'b1;
    @(posedge CK); #1;
    run(4, 0, 4, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
